forward_sel_gen: RTL and testbench



---
 rtl/forward_sel_gen.sv | 117 +++++++++++
 tb/tb_forward_sel_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/forward_sel_gen.sv
// Forwarding select and load-use stall generator for the 5-stage pipeline.
// Ports: clk_i/rst_i (sync, active-low); id_* decoded ID fields; flush_i;
//        fwd_a_o/fwd_b_o registered EX mux selects; stall_o load-use stall.
module forward_sel_gen #(
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rt_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // ID/EX shadow
  logic             r_ex_v;
  logic             r_ex_rw;
  logic             r_ex_mr;
  logic [REG_W-1:0] r_ex_dst;

  // EX/MEM shadow. The MEM/WB entry is not kept: the register file is
  // write-before-read, so nothing ever forwards from beyond EX/MEM's
  // successor, and a select of 01 is decided while the producer is
  // still in EX/MEM (it reaches MEM/WB on the same edge).
  logic             r_mem_v;
  logic             r_mem_rw;
  logic [REG_W-1:0] r_mem_dst;

  logic [1:0]       r_fwd_a;
  logic [1:0]       r_fwd_b;

  logic w_ex_q;
  logic w_mem_q;
  logic w_ex_rs;
  logic w_ex_rt;
  logic w_mem_rs;
  logic w_mem_rt;
  logic w_stall;
  logic w_bubble;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;

  assign w_ex_q  = r_ex_v & r_ex_rw & (r_ex_dst != '0);
  assign w_mem_q = r_mem_v & r_mem_rw & (r_mem_dst != '0);

  assign w_ex_rs  = w_ex_q & (r_ex_dst == id_rs_i);
  assign w_ex_rt  = w_ex_q & (r_ex_dst == id_rt_i);
  assign w_mem_rs = w_mem_q & (r_mem_dst == id_rs_i);
  assign w_mem_rt = w_mem_q & (r_mem_dst == id_rt_i);

  // A load in ID/EX cannot feed a consumer from EX/MEM; hold one cycle.
  assign w_stall = id_valid_i & r_ex_mr & ~flush_i
                 & (w_ex_rs | (id_use_rt_i & w_ex_rt));

  assign w_bubble = flush_i | w_stall | ~id_valid_i;

  // Newest producer wins.
  always_comb begin
    w_sel_a = SEL_RF;
    w_sel_b = SEL_RF;
    if (!w_bubble) begin
      if (w_ex_rs)       w_sel_a = SEL_MEM;
      else if (w_mem_rs) w_sel_a = SEL_WB;
      if (id_use_rt_i) begin
        if (w_ex_rt)       w_sel_b = SEL_MEM;
        else if (w_mem_rt) w_sel_b = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_ex_v    <= 1'b0;
      r_ex_rw   <= 1'b0;
      r_ex_mr   <= 1'b0;
      r_ex_dst  <= '0;
      r_mem_v   <= 1'b0;
      r_mem_rw  <= 1'b0;
      r_mem_dst <= '0;
      r_fwd_a   <= SEL_RF;
      r_fwd_b   <= SEL_RF;
    end else begin
      r_mem_v   <= r_ex_v;
      r_mem_rw  <= r_ex_rw;
      r_mem_dst <= r_ex_dst;
      if (w_bubble) begin
        r_ex_v   <= 1'b0;
        r_ex_rw  <= 1'b0;
        r_ex_mr  <= 1'b0;
        r_ex_dst <= '0;
      end else begin
        r_ex_v   <= 1'b1;
        r_ex_rw  <= id_regwrite_i;
        r_ex_mr  <= id_memread_i;
        r_ex_dst <= id_dst_i;
      end
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end
  end

  assign fwd_a_o = r_fwd_a;
  assign fwd_b_o = r_fwd_b;
  assign stall_o = w_stall;

endmodule

// File: tb/tb_forward_sel_gen.sv
// Self-checking bench for forward_sel_gen: directed instruction
// sequences with literal expectations plus randomized traffic.
module tb_forward_sel_gen;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rt;
  logic [4:0] id_dst;
  logic       id_rw;
  logic       id_mr;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;

  int checks = 0;
  int errors = 0;

  forward_sel_gen #(.REG_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_use_rt_i  (id_use_rt),
    .id_dst_i     (id_dst),
    .id_regwrite_i(id_rw),
    .id_memread_i (id_mr),
    .flush_i      (flush),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .stall_o      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One entry per instruction that entered EX; [0] newest.
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] dst;
  } slot_t;

  slot_t hist[$];

  function automatic bit qual(slot_t s);
    return s.v && s.rw && (s.dst != 5'd0);
  endfunction

  task automatic chk(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp,
               $time);
    end
  endtask

  // Apply one ID cycle, check stall before the edge and selects after.
  // ea/eb/es >= 0 are hand-computed literals checked too.
  task automatic step(input logic r, input logic v,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic fl,
                      input int ea, input int eb, input int es);
    slot_t e, m, n;
    bit ms, bub;
    logic [1:0] ma, mb;
    rst = r; id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rt = ur; id_dst = dst; id_rw = rw; id_mr = mr; flush = fl;
    #1;
    e = hist[0];
    m = hist[1];
    ms = v && qual(e) && e.mr && !fl &&
         (e.dst == rs || (ur && e.dst == rt));
    bub = fl || ms || !v;
    ma = 2'd0;
    mb = 2'd0;
    if (!bub) begin
      if (qual(e) && e.dst == rs)      ma = 2'd2;
      else if (qual(m) && m.dst == rs) ma = 2'd1;
      if (ur) begin
        if (qual(e) && e.dst == rt)      mb = 2'd2;
        else if (qual(m) && m.dst == rt) mb = 2'd1;
      end
    end
    if (r) begin
      chk("stall", {1'b0, stall}, {1'b0, ms});
      if (es >= 0) begin
        chk("stall_lit", {1'b0, stall}, es[1:0]);
        chk("model_stall_lit", {1'b0, ms}, es[1:0]);
      end
    end
    n = '0;
    if (!bub) n = '{v: 1'b1, rw: rw, mr: mr, dst: dst};
    if (!r) begin
      ma = 2'd0;
      mb = 2'd0;
      hist = '{slot_t'(0), slot_t'(0)};
    end else begin
      hist.push_front(n);
      hist = hist[0:1];
    end
    @(posedge clk);
    #1;
    chk("fwd_a", fwd_a, ma);
    chk("fwd_b", fwd_b, mb);
    if (ea >= 0) begin
      chk("fwd_a_lit", fwd_a, ea[1:0]);
      chk("model_a_lit", ma, ea[1:0]);
    end
    if (eb >= 0) begin
      chk("fwd_b_lit", fwd_b, eb[1:0]);
      chk("model_b_lit", mb, eb[1:0]);
    end
  endtask

  task automatic nop2();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hist = '{slot_t'(0), slot_t'(0)};
    // Reset with arbitrary ID inputs
    step(0, 1, 3, 3, 1, 3, 1, 1, 0, 0, 0, -1);
    step(0, 1, 3, 3, 1, 3, 1, 1, 0, 0, 0, -1);
    nop2();
    // add $3,$1,$2 ; sub $4,$3,$3 ; or $5,$3,$1
    step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 3, 1, 4, 1, 0, 0, 2, 2, 0);
    step(1, 1, 3, 1, 1, 5, 1, 0, 0, 1, 0, 0);
    nop2();
    // add $3 ; nop ; or $5,$3,$6
    step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 6, 1, 5, 1, 0, 0, 1, 0, 0);
    nop2();
    // add $3 ; add $3 ; or $5,$3,$3
    step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 3, 1, 5, 1, 0, 0, 2, 2, 0);
    nop2();
    // lw $2,0($1) ; add $4,$2,$7 (stall) ; re-issue
    step(1, 1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0);
    step(1, 1, 2, 7, 1, 4, 1, 0, 0, 0, 0, 1);
    step(1, 1, 2, 7, 1, 4, 1, 0, 0, 1, 0, 0);
    // lw $2 ; addi $4,$5,1 with rt=$2 unused
    step(1, 1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0);
    step(1, 1, 5, 2, 0, 4, 1, 0, 0, 0, 0, 0);
    nop2();
    // add $0,$1,$1 ; add $2,$0,$0
    step(1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    nop2();
    // lw $2 ; dependent add flushed
    step(1, 1, 1, 2, 0, 2, 1, 1, 0, 0, 0, 0);
    step(1, 1, 2, 2, 1, 4, 1, 0, 1, 0, 0, 0);
    nop2();
    // producer, mid-stream reset, dependent
    step(1, 1, 1, 2, 1, 3, 1, 0, 0, -1, -1, -1);
    step(0, 1, 3, 3, 1, 6, 1, 0, 0, 0, 0, -1);
    step(1, 1, 3, 3, 1, 4, 1, 0, 0, 0, 0, 0);
    // Randomized traffic on a small register set
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9) < 8,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0, -1, -1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
